fp_add_normalizer: RTL and testbench

- Post-add stage of the FPU.
- Consumes the signed 27-bit fixed-point sum and overflow flag from the fraction adder, plus the common pre-alignment exponent.
- Converts the result to sign-magnitude, then normalizes it iteratively to single-precision fields: sign, biased exponent and 23-bit truncated mantissa.
- Uses a valid/ready handshake on both sides so the adder result can be consumed and the packer downstream can stall.

---
 rtl/fp_add_normalizer.sv | 144 ++++++++++++++
 tb/tb_fp_add_normalizer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/fp_add_normalizer.sv
// Turns the signed adder sum into sign/biased-exponent/truncated-mantissa fields.
// Latency: 1 cycle if already normalized, plus one cycle per left shift; holds the result until out_ready.
module fp_add_normalizer #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int SUM_W = 27
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [SUM_W-1:0] sum_in,
  input  logic             ovf_in,
  input  logic [EXP_W-1:0] exp_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sign_out,
  output logic [EXP_W-1:0] exp_out,
  output logic [MAN_W-1:0] frac_out,
  output logic             zero_out,
  output logic             oflow_out,
  output logic             uflow_out
);

  localparam int VW = SUM_W + 1;
  localparam logic [EXP_W:0]   EMAX = {1'b0, {EXP_W{1'b1}}};
  localparam logic [EXP_W-1:0] EONE = {{(EXP_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, PREP, SHIFT, DONE} state_t;

  state_t           state;
  logic [VW-1:0]    mag_r;
  logic [EXP_W-1:0] exp_r;
  logic             sign_r;
  logic             zero_r;
  logic             oflow_r;
  logic             uflow_r;

  logic [VW-1:0]    v_cap;
  logic [VW-1:0]    abs_v;
  logic [VW-1:0]    norm_mag;
  logic [EXP_W:0]   esum;
  logic             direct;

  always_comb begin
    // Overflow means the adder dropped the bit above its sign; rebuild it from the sign.
    v_cap    = ovf_in ? {sum_in[SUM_W-1], ~sum_in[SUM_W-1], sum_in[SUM_W-2:0]}
                      : {sum_in[SUM_W-1], sum_in};
    abs_v    = mag_r[VW-1] ? (~mag_r + 1'b1) : mag_r;
    norm_mag = abs_v;
    esum     = {1'b0, exp_r};
    direct   = 1'b1;
    if (abs_v[VW-1]) begin
      norm_mag = abs_v >> 2;
      esum     = {1'b0, exp_r} + (EXP_W+1)'(2);
    end else if (abs_v[VW-2]) begin
      norm_mag = abs_v >> 1;
      esum     = {1'b0, exp_r} + (EXP_W+1)'(1);
    end else if (!abs_v[VW-3]) begin
      direct   = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state   <= IDLE;
      mag_r   <= '0;
      exp_r   <= '0;
      sign_r  <= 1'b0;
      zero_r  <= 1'b0;
      oflow_r <= 1'b0;
      uflow_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mag_r <= v_cap;
            exp_r <= exp_in;
            state <= PREP;
          end
        end
        PREP: begin
          sign_r <= mag_r[VW-1];
          if (abs_v == '0) begin
            zero_r <= 1'b1;
            sign_r <= 1'b0;
            exp_r  <= '0;
            mag_r  <= '0;
            state  <= DONE;
          end else if (direct) begin
            if (esum >= EMAX) begin
              oflow_r <= 1'b1;
              exp_r   <= '1;
              mag_r   <= '0;
            end else begin
              exp_r   <= esum[EXP_W-1:0];
              mag_r   <= norm_mag;
            end
            state <= DONE;
          end else begin
            mag_r <= abs_v;
            // A zero input exponent is already at the floor: no room to shift.
            if (exp_r == '0) begin
              uflow_r <= 1'b1;
              state   <= DONE;
            end else begin
              state   <= SHIFT;
            end
          end
        end
        SHIFT: begin
          if (exp_r <= EONE) begin
            uflow_r <= 1'b1;
            exp_r   <= '0;
            state   <= DONE;
          end else begin
            mag_r <= mag_r << 1;
            exp_r <= exp_r - 1'b1;
            if (mag_r[VW-4]) state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            zero_r  <= 1'b0;
            oflow_r <= 1'b0;
            uflow_r <= 1'b0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign sign_out  = sign_r;
  assign exp_out   = exp_r;
  assign frac_out  = mag_r[MAN_W+1:2];
  assign zero_out  = zero_r;
  assign oflow_out = oflow_r;
  assign uflow_out = uflow_r;

endmodule

// File: tb/tb_fp_add_normalizer.sv
// Bench for fp_add_normalizer: directed corner cases, then random sums against an arithmetic model.
module tb_fp_add_normalizer;

  logic        CLK;
  logic        nRST;
  logic        in_valid;
  logic        in_ready;
  logic [26:0] sum_in;
  logic        ovf_in;
  logic [7:0]  exp_in;
  logic        out_valid;
  logic        out_ready;
  logic        sign_out;
  logic [7:0]  exp_out;
  logic [22:0] frac_out;
  logic        zero_out;
  logic        oflow_out;
  logic        uflow_out;

  int n_chk = 0;
  int n_bad = 0;

  fp_add_normalizer #(.EXP_W(8), .MAN_W(23), .SUM_W(27)) dut (
    .CLK(CLK), .nRST(nRST),
    .in_valid(in_valid), .in_ready(in_ready),
    .sum_in(sum_in), .ovf_in(ovf_in), .exp_in(exp_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .sign_out(sign_out), .exp_out(exp_out), .frac_out(frac_out),
    .zero_out(zero_out), .oflow_out(oflow_out), .uflow_out(uflow_out)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, got, want);
    end
  endtask

  // Value-level model: true sum as an integer, |v|, leading-one position, exponent bounds.
  function automatic void model(input logic [26:0] s, input logic ovf, input int e,
                                output logic sg, output int ex, output int fr,
                                output logic [2:0] fl, output int lat);
    longint v, mag;
    int msb, sh;
    v = longint'(s);
    if (s[26]) v = v - (longint'(1) << 27);
    if (ovf) v = s[26] ? v - (longint'(1) << 26) : v + (longint'(1) << 26);
    sg  = (v < 0);
    mag = sg ? -v : v;
    fl  = 3'b000;
    lat = 1;
    ex  = 0;
    fr  = 0;
    if (mag == 0) begin
      sg = 1'b0;
      fl = 3'b100;
      return;
    end
    msb = 0;
    while ((mag >> (msb + 1)) != 0) msb++;
    if (msb >= 25) begin
      sh = msb - 25;
      ex = e + sh;
      if (ex >= 255) begin
        ex = 255;
        fl = 3'b010;
      end else begin
        fr = int'((mag >> sh) >> 2) & 32'h7FFFFF;
      end
    end else begin
      sh = 25 - msb;
      if (e == 0) begin
        fr = int'(mag >> 2) & 32'h7FFFFF;
        fl = 3'b001;
      end else if (e - sh >= 1) begin
        ex  = e - sh;
        fr  = int'((mag << sh) >> 2) & 32'h7FFFFF;
        lat = 1 + sh;
      end else begin
        fr  = int'((mag << (e - 1)) >> 2) & 32'h7FFFFF;
        fl  = 3'b001;
        lat = e + 1;
      end
    end
  endfunction

  task automatic run_vec(input string tag, input logic [26:0] s, input logic ovf,
                         input int e, input int stall);
    logic       sg;
    logic [2:0] fl;
    int         ex, fr, lat, cnt;
    logic [7:0]  ex8;
    logic [22:0] fr23;
    model(s, ovf, e, sg, ex, fr, fl, lat);
    ex8  = ex[7:0];
    fr23 = fr[22:0];
    @(negedge CLK);
    cnt = 0;
    while (!in_ready && cnt < 50) begin
      @(negedge CLK);
      cnt++;
    end
    chk({tag, "_rdy"}, 64'(in_ready), 64'd1);
    sum_in   = s;
    ovf_in   = ovf;
    exp_in   = e[7:0];
    in_valid = 1'b1;
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
    sum_in   = 27'($urandom);
    ovf_in   = 1'($urandom);
    exp_in   = 8'($urandom);
    cnt = 0;
    do begin
      @(posedge CLK);
      #1;
      cnt++;
    end while (!out_valid && cnt < 400);
    chk({tag, "_lat"},   64'(cnt),      64'(lat));
    chk({tag, "_sign"},  64'(sign_out), 64'(sg));
    chk({tag, "_exp"},   64'(exp_out),  64'(ex8));
    chk({tag, "_frac"},  64'(frac_out), 64'(fr23));
    chk({tag, "_flags"}, 64'({zero_out, oflow_out, uflow_out}), 64'(fl));
    repeat (stall) begin
      @(posedge CLK);
      #1;
      chk({tag, "_hold"},
          64'({out_valid, in_ready, sign_out, exp_out, frac_out, zero_out, oflow_out, uflow_out}),
          64'({1'b1, 1'b0, sg, ex8, fr23, fl}));
    end
    out_ready = 1'b1;
    @(posedge CLK);
    #1;
    out_ready = 1'b0;
    chk({tag, "_ack"}, 64'({out_valid, in_ready, zero_out, oflow_out, uflow_out}), 64'(5'b01000));
  endtask

  initial begin
    logic [26:0] s;
    int          stale;
    nRST      = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    sum_in    = '0;
    ovf_in    = 1'b0;
    exp_in    = '0;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset", 64'({in_ready, out_valid, sign_out, exp_out, frac_out, zero_out, oflow_out, uflow_out}),
        64'({1'b1, 1'b0, 1'b0, 8'd0, 23'd0, 3'b000}));
    @(negedge CLK);
    nRST = 1'b1;

    run_vec("one",     27'h2000000, 1'b0, 127, 1);
    run_vec("negone",  27'h6000000, 1'b0, 130, 0);
    run_vec("ovf2",    27'h0000000, 1'b1, 127, 0);
    run_vec("ovfmax",  27'h0000000, 1'b1, 254, 0);
    run_vec("lsb",     27'h0000001, 1'b0, 127, 0);
    run_vec("floor",   27'h0000100, 1'b0, 5,   0);
    run_vec("zero",    27'h0000000, 1'b0, 77,  5);
    run_vec("exp0",    27'h0001234, 1'b0, 0,   0);
    run_vec("exp1",    27'h0800000, 1'b0, 1,   0);
    run_vec("ovfneg",  27'h4000000, 1'b1, 100, 2);
    run_vec("mixed",   27'h5ABCDEF, 1'b0, 60,  0);
    run_vec("exact1",  27'h0400000, 1'b0, 4,   0);

    // Reset while shifting must drop the operation entirely.
    @(negedge CLK);
    while (!in_ready) @(negedge CLK);
    sum_in   = 27'h0000001;
    ovf_in   = 1'b0;
    exp_in   = 8'd127;
    in_valid = 1'b1;
    @(posedge CLK);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
    nRST = 1'b0;
    #1;
    chk("rst_mid", 64'({out_valid, in_ready, zero_out, oflow_out, uflow_out}), 64'(5'b01000));
    @(negedge CLK);
    nRST  = 1'b1;
    stale = 0;
    repeat (40) begin
      @(posedge CLK);
      #1;
      if (out_valid) stale++;
    end
    chk("rst_stale", 64'(stale), 64'd0);

    for (int i = 0; i < 250; i++) begin
      case ($urandom_range(0, 3))
        0: s = 27'($urandom);
        1: s = 27'($urandom) >> $urandom_range(0, 26);
        2: s = 27'(-(27'($urandom) >> $urandom_range(1, 26)));
        default: s = 27'($urandom) >> $urandom_range(20, 26);
      endcase
      run_vec("rnd", s, ($urandom_range(0, 3) == 0), $urandom_range(0, 254), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_bad);
    $finish;
  end

endmodule
